// File: rtl/interrupt_ctrl_if.sv
// Core-side handshake of the interrupt controller: request/vector out, ack/eret/EPC in.
// master is the controller, slave is the MIPS core.
interface interrupt_ctrl_if;
    logic        ie;
    logic        int_ack;
    logic        eret;
    logic [31:0] epc_in;
    logic        int_req;
    logic [31:0] int_vec;
    logic [31:0] epc_out;

    modport master (
        input  ie, int_ack, eret, epc_in,
        output int_req, int_vec, epc_out
    );

    modport slave (
        output ie, int_ack, eret, epc_in,
        input  int_req, int_vec, epc_out
    );
endinterface

// File: rtl/interrupt_ctrl.sv
// Three-level nested priority interrupt controller: edge-detected requests, per-level
// in-service bits and return addresses, and an IDLE/REQ handshake with the core.
module interrupt_ctrl #(
    parameter logic [31:0] VEC1 = 32'h0000_0100,
    parameter logic [31:0] VEC2 = 32'h0000_0200,
    parameter logic [31:0] VEC3 = 32'h0000_0300
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              inter1,
    input  logic              inter2,
    input  logic              inter3,
    interrupt_ctrl_if.master  bus,
    output logic              inter_running1,
    output logic              inter_running2,
    output logic              inter_running3
);
    typedef enum logic {IDLE, REQ} state_t;

    state_t      state_q;
    logic [3:1]  prev_q, pend_q, isr_q;
    logic [3:1]  pend_d, isr_d;
    logic [3:1]  rise, ack_mask, pop_mask;
    logic [31:0] epc1_q, epc2_q, epc3_q;
    logic [1:0]  req_lvl_q, cur, cand;
    logic        int_req_q;
    logic [31:0] int_vec_q;
    logic        ack_fire;

    function automatic logic [3:1] lvl_mask(input logic [1:0] l);
        case (l)
            2'd1:    lvl_mask = 3'b001;
            2'd2:    lvl_mask = 3'b010;
            2'd3:    lvl_mask = 3'b100;
            default: lvl_mask = '0;
        endcase
    endfunction

    function automatic logic [31:0] vec_of(input logic [1:0] l);
        case (l)
            2'd1:    vec_of = VEC1;
            2'd2:    vec_of = VEC2;
            2'd3:    vec_of = VEC3;
            default: vec_of = '0;
        endcase
    endfunction

    always_comb begin
        cur  = isr_q[3]  ? 2'd3 : isr_q[2]  ? 2'd2 : isr_q[1]  ? 2'd1 : 2'd0;
        cand = pend_q[3] ? 2'd3 : pend_q[2] ? 2'd2 : pend_q[1] ? 2'd1 : 2'd0;
        rise     = {inter3, inter2, inter1} & ~prev_q;
        ack_fire = (state_q == REQ) && bus.int_ack;
        ack_mask = ack_fire ? lvl_mask(req_lvl_q) : '0;
        pop_mask = bus.eret ? lvl_mask(cur) : '0;
        // A fresh edge on the level being acked survives the ack.
        pend_d   = (pend_q & ~ack_mask) | rise;
        isr_d    = (isr_q & ~pop_mask) | ack_mask;
    end

    always_comb begin
        case (cur)
            2'd1:    bus.epc_out = epc1_q;
            2'd2:    bus.epc_out = epc2_q;
            2'd3:    bus.epc_out = epc3_q;
            default: bus.epc_out = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= IDLE;
            prev_q    <= '0;
            pend_q    <= '0;
            isr_q     <= '0;
            epc1_q    <= '0;
            epc2_q    <= '0;
            epc3_q    <= '0;
            req_lvl_q <= '0;
            int_req_q <= 1'b0;
            int_vec_q <= '0;
        end else begin
            prev_q <= {inter3, inter2, inter1};
            pend_q <= pend_d;
            isr_q  <= isr_d;
            if (ack_fire) begin
                case (req_lvl_q)
                    2'd1:    epc1_q <= bus.epc_in;
                    2'd2:    epc2_q <= bus.epc_in;
                    2'd3:    epc3_q <= bus.epc_in;
                    default: ;
                endcase
            end
            case (state_q)
                IDLE: begin
                    if (bus.ie && (cand > cur)) begin
                        req_lvl_q <= cand;
                        int_vec_q <= vec_of(cand);
                        int_req_q <= 1'b1;
                        state_q   <= REQ;
                    end
                end
                REQ: begin
                    // Vector stays frozen; a withdrawn request is re-arbitrated from IDLE.
                    if (bus.int_ack || !bus.ie) begin
                        int_req_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.int_req    = int_req_q;
    assign bus.int_vec    = int_vec_q;
    assign inter_running1 = isr_q[1];
    assign inter_running2 = isr_q[2];
    assign inter_running3 = isr_q[3];
endmodule

// File: tb/tb_interrupt_ctrl.sv
// Directed scenarios from the interrupt controller's behaviour plus a randomized run
// compared against a stack-based reference model of nested interrupt service.
module tb_interrupt_ctrl;
    localparam logic [31:0] V1 = 32'h0000_0100;
    localparam logic [31:0] V2 = 32'h0000_0200;
    localparam logic [31:0] V3 = 32'h0000_0300;

    logic clk = 1'b0;
    logic clr, inter1, inter2, inter3;
    logic r1, r2, r3;
    int unsigned total = 0;
    int unsigned passed = 0;

    interrupt_ctrl_if bus();

    interrupt_ctrl #(.VEC1(V1), .VEC2(V2), .VEC3(V3)) dut (
        .clk            (clk),
        .clr            (clr),
        .inter1         (inter1),
        .inter2         (inter2),
        .inter3         (inter3),
        .bus            (bus),
        .inter_running1 (r1),
        .inter_running2 (r2),
        .inter_running3 (r3)
    );

    always #5 clk = ~clk;

    // Reference model: pending flags plus an explicit stack of (level, return PC).
    bit          m_prev [1:3];
    bit          m_pend [1:3];
    int          m_lvl [$];
    logic [31:0] m_epc [$];
    bit          m_inreq;
    int          m_reqlvl;
    logic [31:0] m_vec;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int lvl);
        if (lvl == 1) inter1 = 1'b1;
        if (lvl == 2) inter2 = 1'b1;
        if (lvl == 3) inter3 = 1'b1;
        cyc(1);
        inter1 = 1'b0;
        inter2 = 1'b0;
        inter3 = 1'b0;
    endtask

    task automatic ack(input logic [31:0] e);
        bus.int_ack = 1'b1;
        bus.epc_in  = e;
        cyc(1);
        bus.int_ack = 1'b0;
    endtask

    task automatic do_eret();
        bus.eret = 1'b1;
        cyc(1);
        bus.eret = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1; inter1 = 1'b0; inter2 = 1'b0; inter3 = 1'b0;
        bus.ie = 1'b0; bus.int_ack = 1'b0; bus.eret = 1'b0; bus.epc_in = '0;
        cyc(2);
        clr = 1'b0;
        total++; if (bus.int_req !== 1'b0) $display("FAIL reset_req got=%0b exp=0", bus.int_req); else passed++;
        total++; if (bus.int_vec !== 32'h0) $display("FAIL reset_vec got=%h exp=0", bus.int_vec); else passed++;
        total++; if (bus.epc_out !== 32'h0) $display("FAIL reset_epc got=%h exp=0", bus.epc_out); else passed++;
        total++; if ({r3, r2, r1} !== 3'b000) $display("FAIL reset_run got=%b exp=000", {r3, r2, r1}); else passed++;
    endtask

    task automatic test_single();
        bus.ie = 1'b1;
        pulse(1);
        total++; if (bus.int_req !== 1'b0) $display("FAIL single_early got=%0b exp=0", bus.int_req); else passed++;
        cyc(1);
        total++; if (bus.int_req !== 1'b1 || bus.int_vec !== V1) $display("FAIL single_req got=%0b/%h exp=1/%h", bus.int_req, bus.int_vec, V1); else passed++;
        ack(32'h40);
        total++; if ({bus.int_req, r1} !== 2'b01 || bus.epc_out !== 32'h40) $display("FAIL single_ack got=%0b%0b/%h exp=01/40", bus.int_req, r1, bus.epc_out); else passed++;
        do_eret();
        total++; if (r1 !== 1'b0 || bus.epc_out !== 32'h0) $display("FAIL single_eret got=%0b/%h exp=0/0", r1, bus.epc_out); else passed++;
        cyc(2);
        total++; if (bus.int_req !== 1'b0) $display("FAIL single_idle got=%0b exp=0", bus.int_req); else passed++;
    endtask

    task automatic test_nesting();
        pulse(2); cyc(1);
        total++; if (bus.int_vec !== V2) $display("FAIL nest_vec2 got=%h exp=%h", bus.int_vec, V2); else passed++;
        ack(32'h80);
        pulse(3); cyc(1);
        total++; if (bus.int_req !== 1'b1 || bus.int_vec !== V3) $display("FAIL nest_vec3 got=%0b/%h exp=1/%h", bus.int_req, bus.int_vec, V3); else passed++;
        ack(32'h304);
        total++; if ({r3, r2, r1} !== 3'b110 || bus.epc_out !== 32'h304) $display("FAIL nest_push got=%b/%h exp=110/304", {r3, r2, r1}, bus.epc_out); else passed++;
        pulse(1); cyc(2);
        total++; if (bus.int_req !== 1'b0) $display("FAIL nest_low_blocked got=%0b exp=0", bus.int_req); else passed++;
        do_eret(); cyc(2);
        total++; if (bus.epc_out !== 32'h80 || bus.int_req !== 1'b0 || {r3, r2} !== 2'b01) $display("FAIL nest_pop3 got=%h/%0b/%b exp=80/0/01", bus.epc_out, bus.int_req, {r3, r2}); else passed++;
        do_eret();
        total++; if (bus.int_req !== 1'b0 || bus.epc_out !== 32'h0) $display("FAIL nest_pop2 got=%0b/%h exp=0/0", bus.int_req, bus.epc_out); else passed++;
        cyc(1);
        total++; if (bus.int_req !== 1'b1 || bus.int_vec !== V1) $display("FAIL nest_release got=%0b/%h exp=1/%h", bus.int_req, bus.int_vec, V1); else passed++;
        ack(32'h10);
        do_eret();
    endtask

    task automatic test_low_under_high();
        pulse(3); cyc(1);
        ack(32'h300);
        pulse(1); cyc(3);
        total++; if (bus.int_req !== 1'b0 || r3 !== 1'b1) $display("FAIL luh_blocked got=%0b/%0b exp=0/1", bus.int_req, r3); else passed++;
        do_eret(); cyc(1);
        total++; if (bus.int_req !== 1'b1 || bus.int_vec !== V1) $display("FAIL luh_release got=%0b/%h exp=1/%h", bus.int_req, bus.int_vec, V1); else passed++;
        ack(32'h20);
        do_eret();
    endtask

    task automatic test_mask_withdraw();
        bus.ie = 1'b0;
        pulse(3); cyc(3);
        total++; if (bus.int_req !== 1'b0) $display("FAIL mask_off got=%0b exp=0", bus.int_req); else passed++;
        bus.ie = 1'b1;
        cyc(2);
        total++; if (bus.int_req !== 1'b1 || bus.int_vec !== V3) $display("FAIL mask_on got=%0b/%h exp=1/%h", bus.int_req, bus.int_vec, V3); else passed++;
        bus.ie = 1'b0;
        cyc(1);
        total++; if (bus.int_req !== 1'b0 || bus.int_vec !== V3) $display("FAIL withdraw got=%0b/%h exp=0/%h", bus.int_req, bus.int_vec, V3); else passed++;
        cyc(2);
        bus.ie = 1'b1;
        cyc(1);
        total++; if (bus.int_req !== 1'b1 || bus.int_vec !== V3) $display("FAIL reissue got=%0b/%h exp=1/%h", bus.int_req, bus.int_vec, V3); else passed++;
        ack(32'h77);
        do_eret();
    endtask

    task automatic test_simultaneous();
        inter1 = 1'b1; inter3 = 1'b1;
        cyc(1);
        inter1 = 1'b0; inter3 = 1'b0;
        cyc(1);
        total++; if (bus.int_vec !== V3) $display("FAIL simul_first got=%h exp=%h", bus.int_vec, V3); else passed++;
        ack(32'h500);
        total++; if (r3 !== 1'b1 || bus.int_req !== 1'b0) $display("FAIL simul_ack got=%0b/%0b exp=1/0", r3, bus.int_req); else passed++;
        do_eret(); cyc(1);
        total++; if (bus.int_req !== 1'b1 || bus.int_vec !== V1) $display("FAIL simul_second got=%0b/%h exp=1/%h", bus.int_req, bus.int_vec, V1); else passed++;
        ack(32'h600);
        do_eret();
    endtask

    task automatic test_reset_mid();
        pulse(2); cyc(1);
        ack(32'h80);
        pulse(1);
        pulse(3); cyc(1);
        total++; if (bus.int_req !== 1'b1 || r2 !== 1'b1) $display("FAIL rmid_setup got=%0b/%0b exp=1/1", bus.int_req, r2); else passed++;
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        total++; if ({bus.int_req, r3, r2, r1} !== 4'b0000 || bus.int_vec !== 32'h0 || bus.epc_out !== 32'h0)
            $display("FAIL rmid_clear got=%b/%h/%h exp=0000/0/0", {bus.int_req, r3, r2, r1}, bus.int_vec, bus.epc_out); else passed++;
        cyc(4);
        total++; if (bus.int_req !== 1'b0) $display("FAIL rmid_noreissue got=%0b exp=0", bus.int_req); else passed++;
    endtask

    task automatic test_random();
        bit          c, ie, ak, er, acked;
        bit          in [1:3];
        bit          new_pend [1:3];
        logic [31:0] ep, exp_epc;
        logic [3:1]  exp_run;
        int          cur, cand;
        for (int unsigned i = 0; i < 1500; i++) begin
            c  = (i == 0) || ($urandom_range(0, 199) == 0);
            ie = ($urandom_range(0, 7) != 0);
            ak = m_inreq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            er = ($urandom_range(0, 5) == 0);
            ep = $urandom;
            for (int n = 1; n <= 3; n++) in[n] = ($urandom_range(0, 3) == 0);
            clr = c; bus.ie = ie; bus.int_ack = ak; bus.eret = er; bus.epc_in = ep;
            inter1 = in[1]; inter2 = in[2]; inter3 = in[3];
            @(posedge clk);
            if (c) begin
                m_prev = '{0, 0, 0}; m_pend = '{0, 0, 0};
                m_lvl.delete(); m_epc.delete();
                m_inreq = 0; m_reqlvl = 0; m_vec = '0;
            end else begin
                cur  = (m_lvl.size() != 0) ? m_lvl[$] : 0;
                cand = 0;
                for (int n = 1; n <= 3; n++) if (m_pend[n]) cand = n;
                acked    = m_inreq && ak;
                new_pend = m_pend;
                if (acked) new_pend[m_reqlvl] = 0;
                for (int n = 1; n <= 3; n++) if (in[n] && !m_prev[n]) new_pend[n] = 1;
                if (er && m_lvl.size() != 0) begin
                    void'(m_lvl.pop_back());
                    void'(m_epc.pop_back());
                end
                if (acked) begin
                    m_lvl.push_back(m_reqlvl);
                    m_epc.push_back(ep);
                end
                if (m_inreq) begin
                    if (ak || !ie) m_inreq = 0;
                end else if (ie && cand > cur) begin
                    m_inreq  = 1;
                    m_reqlvl = cand;
                    m_vec    = (cand == 3) ? V3 : (cand == 2) ? V2 : V1;
                end
                m_pend = new_pend;
                m_prev = in;
            end
            exp_run = '0;
            foreach (m_lvl[k]) exp_run[m_lvl[k]] = 1'b1;
            exp_epc = (m_epc.size() != 0) ? m_epc[$] : 32'h0;
            #1;
            total++; if (bus.int_req !== m_inreq) $display("FAIL rnd_req cyc=%0d got=%0b exp=%0b", i, bus.int_req, m_inreq); else passed++;
            total++; if (bus.int_vec !== m_vec) $display("FAIL rnd_vec cyc=%0d got=%h exp=%h", i, bus.int_vec, m_vec); else passed++;
            total++; if (bus.epc_out !== exp_epc) $display("FAIL rnd_epc cyc=%0d got=%h exp=%h", i, bus.epc_out, exp_epc); else passed++;
            total++; if ({r3, r2, r1} !== exp_run) $display("FAIL rnd_run cyc=%0d got=%b exp=%b", i, {r3, r2, r1}, exp_run); else passed++;
        end
        clr = 1'b0; bus.int_ack = 1'b0; bus.eret = 1'b0;
        inter1 = 1'b0; inter2 = 1'b0; inter3 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_nesting();
        test_low_under_high();
        test_mask_withdraw();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/interrupt_ctrl.md
# interrupt_ctrl

Three-level nested priority interrupt controller between the external sources `inter1`..`inter3` and the MIPS core. It edge-detects and latches requests, arbitrates them against the level currently in service, and handshakes each entry with the core (`int_req`/`int_ack`). It keeps one return address per level and tracks exits through `eret`, so a higher level can pre-empt a lower one. It drives `inter_running1`..`inter_running3` for the top level and board LEDs.

## Interface
- `VEC1`, default 32'h0000_0100: handler address for level 1 (lowest priority).
- `VEC2`, default 32'h0000_0200: handler address for level 2.
- `VEC3`, default 32'h0000_0300: handler address for level 3 (highest priority).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `clr`  in  1  reset, synchronous, active-high.
- `inter1`, `inter2`, `inter3`  in  1  request pulses from the sources.
  - Each pulse must be high for at least one clk rising edge.
  - A 0→1 transition seen between consecutive edges counts as one request.
- `ie`  in  1  global interrupt enable from the core.
- `int_ack`  in  1  core accepts the presented interrupt at an instruction boundary.
- `eret`  in  1  core retires the return-from-interrupt instruction.
- `epc_in`  in  32  return PC supplied by the core with `int_ack`.
- `int_req`  out  1  interrupt request to the core.
- `int_vec`  out  32  handler address; valid while `int_req`=1.
- `epc_out`  out  32  return PC of the highest in-service level.
- `inter_running1`, `inter_running2`, `inter_running3`  out  1  in-service bit of each level.

## Operation
- **Edge detect.** `prev[n]` registers `inter_n` every cycle. `prev` is cleared by `clr`, so an input that is high at the first post-reset edge counts as a request.
- **Pending.**
  - `pend[n]` is set on an edge where `inter_n`=1 and `prev[n]`=0.
  - It is cleared when level n is acked.
  - If a set and a clear coincide, set wins, so a new request arriving during the ack is not lost.
- **In-service.**
  - `isr[3:1]` drives `inter_running3`..`inter_running1` directly.
  - `cur` is the highest set `isr` bit, or 0 when none are set.
  - `cand` is the highest set `pend` bit.
- **EPC.**
  - `epc1`..`epc3` are 32-bit registers.
  - `epc_out` = `epc[cur]`, or 0 when `cur`=0. It is combinational from the registers.
- **FSM state IDLE.**
  - If `ie`=1 and `cand` > `cur`: latch `req_lvl` = `cand`, load `int_vec` = `VEC[cand]`, go to REQ.
  - `int_req` is asserted as a registered output.
- **FSM state REQ.**
  - `int_req`=1 and `int_vec` stay frozen, even if a higher level becomes pending.
  - On `int_ack`=1: set `isr[req_lvl]`, clear `pend[req_lvl]`, store `epc[req_lvl]` ← `epc_in`, drop `int_req`, return to IDLE.
  - If `ie`=0 while `int_ack`=0: withdraw (`int_req`←0, `int_vec` held) and return to IDLE. `pend` is untouched.
- **eret** (any state): clear `isr[cur]`. If `cur`=0, `eret` is ignored.
- **eret and int_ack in the same cycle.** The pop is applied to the old `cur` and the push to `req_lvl`. Both take effect at the same edge.
- **Ignored acks.** `int_ack` in IDLE is ignored.
- **Lower-priority requests.** A request at or below `cur` stays pending until `cur` drops below it, then it is issued.
- **Reset.** `clr`=1 at any edge clears `prev`, `pend`, `isr`, `epc1`..`epc3` and the FSM (→ IDLE). The outputs reset as follows:
  - `int_req`=0
  - `int_vec`=0
  - `epc_out`=0
  - all `inter_running`=0
- **Reset mid-handshake.** This cancels everything; no request is reissued afterwards.

## Timing
- Source input first sampled high at edge N → `pend` set at N → `int_req`=1 and `int_vec` valid after edge N+1. This 2-edge latency applies when `ie`=1 and the level out-ranks `cur`.
- `int_ack` sampled at edge M → after M: `int_req`=0, `inter_running`=1, `epc_out`=`epc_in`@M.
- Back-to-back requests: the earliest next `int_req` is 1 cycle after the ack edge (IDLE re-evaluates at M+1, so `int_req` rises after edge M+1).
- `eret` sampled at edge E → `inter_running[cur]`=0 and `epc_out` updated after E. A waiting pending level raises `int_req` after edge E+1.
- Simultaneous edges on several inputs: all are latched; the highest level is issued first.

## Test plan
- **Single level 1.** `ie`=1, pulse `inter1` → `int_req`=1 and `int_vec`=0x100 two edges later. Ack with `epc_in`=0x40 → `inter_running1`=1, `epc_out`=0x40. Then `eret` → `inter_running1`=0, `epc_out`=0.
- **Nesting 2→3→1.**
  - Ack level 2 (`epc_in`=0x80); pulse `inter3` → `int_vec`=0x300. Ack with `epc_in`=0x304 → `inter_running2`=1 and `inter_running3`=1, `epc_out`=0x304.
  - Pulse `inter1` → no `int_req`.
  - `eret` → `epc_out`=0x80, still no `int_req`.
  - Second `eret` → `int_req`=1, `int_vec`=0x100.
- **Low under high.** Level 3 in service; pulse `inter1` → `int_req` stays 0. After `eret`, `int_req`=1 with `int_vec`=0x100.
- **Mask and withdraw.**
  - `ie`=0, pulse `inter3` → no `int_req`; set `ie`=1 → `int_req`=1 two edges later.
  - While in REQ, drop `ie` → `int_req`=0 next edge; restore `ie` → request reissued.
- **Simultaneous sources.** `inter1` and `inter3` rise on the same edge → `int_vec`=0x300 first. After its ack and `eret`, `int_vec`=0x100.
- **Reset mid-operation.** Level 2 in service, level 1 pending, `int_req`=1; assert `clr` for one edge → all outputs 0. No `int_req` follows with `ie`=1 and the inputs low.
